// File: rtl/muldiv_pkg.sv
// Shared constants, opcode encodings and FSM state type for the EX-stage M-extension unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = 32;

  localparam logic [5:0] IterLast = 6'(ITER - 1);
  localparam logic [5:0] IterFull = 6'(ITER);

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider datapath: one quotient bit per step, 32 steps per divide.
module div_iter
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nx_o,
  output logic [XLEN-1:0] rem_nx_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // The *_nx_o outputs are the values after the current step, so the caller
  // can capture the final result on the same edge as the last step.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[XLEN]) begin
      rem_nx_o = shifted[XLEN-1:0];
      quo_nx_o = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nx_o = diff[XLEN-1:0];
      quo_nx_o = {quo_q[XLEN-2:0], 1'b1};
    end

    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      rem_d = rem_nx_o;
      quo_d = quo_nx_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle instead.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [63:0]     prod_q, prod_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            done_q, done_d;

  logic            accept, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, div_load, div_step, fast_hit;
  logic [XLEN-1:0] a_mag, b_mag, special_res, fast_res;
  logic [XLEN-1:0] quo_nx, rem_nx, quo_fix, rem_fix, div_res, mul_res;
  logic [XLEN:0]   mul_sum;
  logic [63:0]     prod_nx, prod_fix;

  assign accept = (state_q == StIdle) && start && !flush;
  assign stall  = rst && !flush && (((state_q == StIdle) && start) || (state_q == StCalc));
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;

  // Operand decode for the incoming instruction.
  always_comb begin
    a_sgn    = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    b_sgn    = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    a_neg    = a_sgn && A[XLEN-1];
    b_neg    = b_sgn && B[XLEN-1];
    a_mag    = a_neg ? (32'd0 - A) : A;
    b_mag    = b_neg ? (32'd0 - B) : B;
    div_zero = op[2] && (B == '0);
    div_ovf  = ((op == OpDiv) || (op == OpRem)) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    if (div_zero) special_res = op[1] ? A : 32'hFFFF_FFFF;
    else          special_res = op[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_a, fast_b, fast_p;

  // 33x33 signed product; sign-extending to 64 bits keeps the low 64 bits exact.
  always_comb begin
    fast_a   = {{32{a_sgn && A[XLEN-1]}}, A};
    fast_b   = {{32{b_sgn && B[XLEN-1]}}, B};
    fast_p   = fast_a * fast_b;
    fast_res = (op == OpMul) ? fast_p[31:0] : fast_p[63:32];
  end
  assign fast_hit = !op[2];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // One shift-add step on the magnitude product; multiplier sits in the low word.
  always_comb begin
    mul_sum  = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? mcand_q : 32'd0)};
    prod_nx  = {mul_sum, prod_q[31:1]};
    prod_fix = neg_q ? (64'd0 - prod_nx) : prod_nx;
    mul_res  = (op_q == OpMul) ? prod_fix[31:0] : prod_fix[63:32];
    quo_fix  = neg_q ? (32'd0 - quo_nx) : quo_nx;
    rem_fix  = rneg_q ? (32'd0 - rem_nx) : rem_nx;
    div_res  = op_q[1] ? rem_fix : quo_fix;
  end

  div_iter u_div_iter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_nx_o   (quo_nx),
    .rem_nx_o   (rem_nx)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d     = op;
          rd_d     = rd_in;
          cnt_d    = '0;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          prod_d   = {32'd0, b_mag};
          mcand_d  = a_mag;
          div_load = 1'b1;
          if (div_zero || div_ovf || fast_hit) begin
            result_d = fast_hit ? fast_res : special_res;
            done_d   = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        cnt_d    = (cnt_q == IterFull) ? cnt_q : cnt_q + 6'd1;
        div_step = op_q[2];
        if (!op_q[2]) prod_d = prod_nx;
        if (cnt_q == IterLast) begin
          result_d = op_q[2] ? div_res : mul_res;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Flush wins over everything, including a completion on this edge.
    if (flush) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table plus scoreboard, and hand-written
// sequences for ignored start, flush and asynchronous reset.
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic [4:0]  rd_in;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk    (clk),
    .rst    (rst_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .rd_in  (rd_in),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  vec_t tbl [16];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb64, ua, ub, p;
    logic        ovf;
    logic [31:0] r;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r    = '0;
    case (o)
      3'd0: begin p = ua * ub;   r = p[31:0];  end
      3'd1: begin p = sa * sb64; r = p[63:32]; end
      3'd2: begin p = sa * ub;   r = p[63:32]; end
      3'd3: begin p = ua * ub;   r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = o[2] && ((b == 0) ||
              ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (special || (!o[2] && FastMul)) ? 1 : 33;
  endfunction

  // Waits for done with a cycle budget; k = cycles since the start cycle, -1 on timeout.
  task automatic wait_done(input int k0, output int k, output bit sok);
    k   = k0;
    sok = 1'b1;
    forever begin
      @(negedge clk);
      k++;
      if (done) break;
      if (!stall) sok = 1'b0;
      if (k >= 40) begin
        k = -1;
        break;
      end
    end
  endtask

  task automatic finish_op(input string name, input int k, input int lat, input bit sok);
    exp_t e;
    chk({name, " latency"}, 64'(k), 64'(lat));
    if (k < 0) begin
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    chk({name, " stall_busy"}, 64'(sok), 64'd1);
    chk({name, " stall_at_done"}, 64'(stall), 64'd0);
    chk({name, " sb_pending"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({name, " result"}, 64'(result), 64'(e.res));
    chk({name, " rd_out"}, 64'(rd_out), 64'(e.rd));
    @(negedge clk);
    chk({name, " done_pulse"}, 64'(done), 64'd0);
    chk({name, " result_hold"}, 64'(result), 64'(e.res));
  endtask

  // Call in the low clock phase; returns in the low phase one cycle after done.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res);
    int k;
    bit sok;
    op    = o;
    A     = a;
    B     = b;
    rd_in = rd;
    start = 1'b1;
    sb.push_back('{res: res, rd: rd});
    #1 chk({name, " stall_start"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, k, sok);
    finish_op(name, k, exp_lat(o, a, b), sok);
  endtask

  task automatic watch_no_done(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int          k;
    bit          sok;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rr;

    tbl[0]  = '{op: 3'd4, a: 32'hFFFF_FFF9, b: 32'd2,          res: 32'hFFFF_FFFD};
    tbl[1]  = '{op: 3'd6, a: 32'hFFFF_FFF9, b: 32'd2,          res: 32'hFFFF_FFFF};
    tbl[2]  = '{op: 3'd7, a: 32'd7,         b: 32'd0,          res: 32'd7};
    tbl[3]  = '{op: 3'd4, a: 32'h8000_0000, b: 32'hFFFF_FFFF, res: 32'h8000_0000};
    tbl[4]  = '{op: 3'd1, a: 32'h8000_0000, b: 32'h8000_0000, res: 32'h4000_0000};
    tbl[5]  = '{op: 3'd3, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'hFFFF_FFFE};
    tbl[6]  = '{op: 3'd0, a: 32'h1234_5678, b: 32'h10,        res: 32'h2345_6780};
    tbl[7]  = '{op: 3'd2, a: 32'hFFFF_FFFF, b: 32'd2,          res: 32'hFFFF_FFFF};
    tbl[8]  = '{op: 3'd5, a: 32'd100,       b: 32'd7,          res: 32'd14};
    tbl[9]  = '{op: 3'd6, a: 32'h8000_0000, b: 32'hFFFF_FFFF, res: 32'd0};
    tbl[10] = '{op: 3'd4, a: 32'd5,         b: 32'd0,          res: 32'hFFFF_FFFF};
    tbl[11] = '{op: 3'd7, a: 32'hFFFF_FFFF, b: 32'h10,        res: 32'hF};
    tbl[12] = '{op: 3'd4, a: 32'd7,         b: 32'hFFFF_FFFE, res: 32'hFFFF_FFFD};
    tbl[13] = '{op: 3'd6, a: 32'd7,         b: 32'hFFFF_FFFE, res: 32'd1};
    tbl[14] = '{op: 3'd0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'd1};
    tbl[15] = '{op: 3'd1, a: 32'hFFFF_FFFF, b: 32'd1,          res: 32'hFFFF_FFFF};

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    A     = '0;
    B     = '0;
    rd_in = '0;
    #12;
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset rd_out", 64'(rd_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].res);
    end

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      rr = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", i), ro, ra, rb, rr, ref_op(ro, ra, rb));
    end

    // A start arriving mid-calculation must be ignored.
    op    = 3'd5;
    A     = 32'd1000;
    B     = 32'd7;
    rd_in = 5'd3;
    start = 1'b1;
    sb.push_back('{res: 32'd142, rd: 5'd3});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    op    = 3'd0;
    A     = 32'd3;
    B     = 32'd3;
    rd_in = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(2, k, sok);
    finish_op("ignore_start", k, 33, sok);

    // Flush DIVU at N+10: idle at N+11, no done, stall drops in the flush cycle.
    op    = 3'd5;
    A     = 32'd1000;
    B     = 32'd3;
    rd_in = 5'd17;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush stall_low", 64'(stall), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush idle_stall", 64'(stall), 64'd0);
    chk("flush rd_hold", 64'(rd_out), 64'd17);
    watch_no_done("flush no_done", 40);

    // Flush together with start in IDLE accepts nothing.
    op    = 3'd4;
    A     = 32'd50;
    B     = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    #1 chk("flush_start stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 begin
      start = 1'b0;
      flush = 1'b0;
    end
    watch_no_done("flush_start no_done", 40);
    run_op("after_flush", 3'd5, 32'd1000, 32'd3, 5'd18, 32'd333);

    // Asynchronous reset at N+5 of a DIV.
    op    = 3'd4;
    A     = 32'd99;
    B     = 32'd4;
    rd_in = 5'd21;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst stall", 64'(stall), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst result", 64'(result), 64'd0);
    chk("arst rd_out", 64'(rd_out), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("arst no_done", 40);
    run_op("b2b_a", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd22, 32'hFFFF_FFF2);
    run_op("b2b_b", 3'd3, 32'h0001_0000, 32'h0001_0000, 5'd23, 32'd1);

    chk("sb drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
